rom_read_sequencer: RTL and testbench

Parametrised ROM read front-end, successor to the single-address ROM input interface. Accepts one burst command at a time (start address, beat count, address mode) and drives the ROM address port for one address per cycle. It tracks the ROM's fixed read latency and returns each word with a valid flag and a last-beat marker. It sits between the testbench/controller command source and the ROM DUT.

---
 rtl/rom_read_sequencer_if.sv | 34 +++
 rtl/rom_read_sequencer.sv | 129 ++++++++++++
 tb/tb_rom_read_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/rom_read_sequencer_if.sv
`default_nettype none
// ==========================================================================
// rom_read_sequencer_if : command, ROM address/data and read-return bundle
// Revision: 1.0
// ==========================================================================
interface rom_read_sequencer_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_start;
  logic [LEN_W-1:0]  cmd_len;
  logic [1:0]        cmd_mode;
  logic [ADDR_W-1:0] address;
  logic              addr_en;
  logic [DATA_W-1:0] rom_data;
  logic              rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              rd_last;
  logic              busy;

  modport master (
    output cmd_valid, cmd_start, cmd_len, cmd_mode, rom_data,
    input  cmd_ready, address, addr_en, rd_valid, rd_data, rd_last, busy
  );

  modport slave (
    input  cmd_valid, cmd_start, cmd_len, cmd_mode, rom_data,
    output cmd_ready, address, addr_en, rd_valid, rd_data, rd_last, busy
  );
endinterface
`default_nettype wire

// File: rtl/rom_read_sequencer.sv
`default_nettype none
// ==========================================================================
// rom_read_sequencer : burst ROM read front-end with latency-tracked returns
// Revision: 1.0
// ==========================================================================
module rom_read_sequencer #(
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8,
  parameter int LEN_W   = 8,
  parameter int ROM_LAT = 1
) (
  input  wire logic              clk,
  input  wire logic              reset_n,
  rom_read_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        mode_q, mode_d;
  logic [ROM_LAT-1:0] vld_q, vld_d;
  logic [ROM_LAT-1:0] lst_q, lst_d;
  logic              rd_valid_q;
  logic              rd_last_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [ADDR_W-1:0] addr_next;
  logic              issue;
  logic              issue_last;

  assign issue      = (state_q == S_RUN);
  assign issue_last = issue && (cnt_q == '0);

  always_comb begin
    case (mode_q)
      2'b01:   addr_next = addr_q - ADDR_W'(1);
      2'b10:   addr_next = addr_q;
      default: addr_next = addr_q + ADDR_W'(1);
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    case (state_q)
      S_IDLE: begin
        if (bus.cmd_valid) begin
          state_d = S_RUN;
          addr_d  = bus.cmd_start;
          cnt_d   = bus.cmd_len;
          mode_d  = bus.cmd_mode;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q - LEN_W'(1);
        // The final beat's address is kept so the port holds it while idle.
        if (cnt_q == '0) begin
          state_d = S_DRAIN;
        end else begin
          addr_d = addr_next;
        end
      end
      S_DRAIN: begin
        if (rd_valid_q && rd_last_q) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  if (ROM_LAT == 1) begin : g_pipe_single
    assign vld_d = issue;
    assign lst_d = issue_last;
  end else begin : g_pipe_multi
    assign vld_d = {vld_q[ROM_LAT-2:0], issue};
    assign lst_d = {lst_q[ROM_LAT-2:0], issue_last};
  end

  // Tail of the pipeline lines up with the cycle rom_data is valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_q      <= '0;
      lst_q      <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      vld_q      <= vld_d;
      lst_q      <= lst_d;
      rd_valid_q <= vld_q[ROM_LAT-1];
      rd_last_q  <= vld_q[ROM_LAT-1] & lst_q[ROM_LAT-1];
      if (vld_q[ROM_LAT-1]) begin
        rd_data_q <= bus.rom_data;
      end
    end
  end

  assign bus.cmd_ready = (state_q == S_IDLE);
  assign bus.busy      = (state_q != S_IDLE);
  assign bus.addr_en   = issue;
  assign bus.address   = addr_q;
  assign bus.rd_valid  = rd_valid_q;
  assign bus.rd_data   = rd_data_q;
  assign bus.rd_last   = rd_last_q;

endmodule
`default_nettype wire

// File: tb/tb_rom_read_sequencer.sv
`default_nettype none
// ==========================================================================
// tb_rom_read_sequencer : four sequencers (ROM_LAT 1..4) against a timeline model
// Revision: 1.0
// ==========================================================================
module tb_rom_read_sequencer;

  localparam int NDUT = 4;
  localparam int MAXC = 4096;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic [7:0] cmd_start = 8'h00;
  logic [7:0] cmd_len = 8'h00;
  logic [1:0] cmd_mode = 2'b00;

  logic [NDUT-1:0] o_ready, o_busy, o_aen, o_rv, o_rl;
  logic [7:0]      o_addr [NDUT];
  logic [7:0]      o_rd   [NDUT];

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  bit       exp_aen  [NDUT][MAXC];
  bit [7:0] exp_addr [NDUT][MAXC];
  bit       exp_rv   [NDUT][MAXC];
  bit [7:0] exp_rd   [NDUT][MAXC];
  bit       exp_rl   [NDUT][MAXC];
  bit       exp_busy [NDUT][MAXC];
  int       free_at  [NDUT];
  int       accepts  [NDUT];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    rom_read_sequencer_if #(.ADDR_W(8), .DATA_W(8), .LEN_W(8)) bus ();
    logic [7:0] rom_pipe [k+1];

    assign bus.cmd_valid = cmd_valid;
    assign bus.cmd_start = cmd_start;
    assign bus.cmd_len   = cmd_len;
    assign bus.cmd_mode  = cmd_mode;
    assign bus.rom_data  = rom_pipe[k];

    always @(posedge clk) begin
      rom_pipe[0] <= bus.address ^ 8'hA5;
      for (int j = 1; j <= k; j++) rom_pipe[j] <= rom_pipe[j-1];
    end

    rom_read_sequencer #(
      .ADDR_W(8), .DATA_W(8), .LEN_W(8), .ROM_LAT(k + 1)
    ) u_dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
    );

    assign o_ready[k] = bus.cmd_ready;
    assign o_busy[k]  = bus.busy;
    assign o_aen[k]   = bus.addr_en;
    assign o_addr[k]  = bus.address;
    assign o_rv[k]    = bus.rd_valid;
    assign o_rd[k]    = bus.rd_data;
    assign o_rl[k]    = bus.rd_last;
  end

  task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s dut_lat%0d cyc %0d observed %0h expected %0h", tag, k + 1, cyc, obs, expv);
    end
  endtask

  // Beat i of a burst: start +/- i modulo 256, or held start.
  function automatic logic [7:0] beat_addr(input int s, input int m, input int i);
    if (m == 1)      return 8'(s - i);
    else if (m == 2) return 8'(s);
    else             return 8'(s + i);
  endfunction

  // Burst accepted at edge e0: beats in cycles e0..e0+N-1, returns LAT+1 later.
  task automatic schedule(input int k, input int e0);
    int n, lat;
    logic [7:0] a;
    n = int'(cmd_len) + 1;
    lat = k + 1;
    for (int i = 0; i < n; i++) begin
      a = beat_addr(int'(cmd_start), int'(cmd_mode), i);
      exp_aen[k][e0+i]          = 1'b1;
      exp_addr[k][e0+i]         = a;
      exp_rv[k][e0+i+lat+1]     = 1'b1;
      exp_rd[k][e0+i+lat+1]     = a ^ 8'hA5;
      exp_rl[k][e0+i+lat+1]     = (i == n - 1);
    end
    for (int c = e0; c <= e0 + n + lat; c++) exp_busy[k][c] = 1'b1;
    free_at[k] = e0 + n + lat + 1;
    accepts[k]++;
  endtask

  task automatic step();
    if (reset_n) begin
      for (int k = 0; k < NDUT; k++)
        if (cyc >= free_at[k] && cmd_valid) schedule(k, cyc + 1);
    end
    @(posedge clk);
    cyc++;
    @(negedge clk);
    for (int k = 0; k < NDUT; k++) begin
      chk("addr_en", k, 32'(o_aen[k]), 32'(exp_aen[k][cyc]));
      if (exp_aen[k][cyc]) chk("address", k, 32'(o_addr[k]), 32'(exp_addr[k][cyc]));
      chk("rd_valid", k, 32'(o_rv[k]), 32'(exp_rv[k][cyc]));
      if (exp_rv[k][cyc]) chk("rd_data", k, 32'(o_rd[k]), 32'(exp_rd[k][cyc]));
      chk("rd_last", k, 32'(o_rl[k]), 32'(exp_rl[k][cyc]));
      chk("busy", k, 32'(o_busy[k]), 32'(exp_busy[k][cyc]));
      chk("cmd_ready", k, 32'(o_ready[k]), 32'(!exp_busy[k][cyc]));
    end
  endtask

  function automatic bit all_idle();
    for (int k = 0; k < NDUT; k++) if (free_at[k] > cyc) return 1'b0;
    return 1'b1;
  endfunction

  task automatic wait_idle();
    for (int n = 0; n < 200 && !all_idle(); n++) step();
  endtask

  task automatic burst(input logic [7:0] s, input logic [7:0] l, input logic [1:0] m);
    wait_idle();
    cmd_start = s;
    cmd_len   = l;
    cmd_mode  = m;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic check_reset_vals();
    for (int k = 0; k < NDUT; k++) begin
      chk("rst_ready", k, 32'(o_ready[k]), 32'd1);
      chk("rst_busy", k, 32'(o_busy[k]), 32'd0);
      chk("rst_aen", k, 32'(o_aen[k]), 32'd0);
      chk("rst_addr", k, 32'(o_addr[k]), 32'd0);
      chk("rst_rv", k, 32'(o_rv[k]), 32'd0);
      chk("rst_rd", k, 32'(o_rd[k]), 32'd0);
      chk("rst_rl", k, 32'(o_rl[k]), 32'd0);
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    #1;
    check_reset_vals();
    for (int k = 0; k < NDUT; k++) begin
      for (int c = cyc; c < MAXC; c++) begin
        exp_aen[k][c]  = 1'b0;
        exp_rv[k][c]   = 1'b0;
        exp_rl[k][c]   = 1'b0;
        exp_busy[k][c] = 1'b0;
      end
      free_at[k] = 0;
    end
  endtask

  int held_target;

  initial begin
    for (int k = 0; k < NDUT; k++) begin
      free_at[k] = 0;
      accepts[k] = 0;
    end

    // Power-on reset
    repeat (3) step();
    check_reset_vals();
    reset_n = 1'b1;
    step();

    // Directed bursts: basic, wrap, decrement, hold, single beat, latency sweep
    burst(8'h10, 8'd3, 2'b00);
    burst(8'hFE, 8'd3, 2'b00);
    burst(8'h01, 8'd2, 2'b01);
    burst(8'h42, 8'd2, 2'b10);
    burst(8'h7C, 8'd0, 2'b00);
    burst(8'h00, 8'd7, 2'b00);
    burst(8'hFD, 8'd4, 2'b11);

    // Randomized bursts
    for (int r = 0; r < 8; r++)
      burst(8'($urandom_range(0, 255)), 8'($urandom_range(0, 20)), 2'($urandom_range(0, 3)));

    // Command held while busy, with a changing start address
    wait_idle();
    cmd_start = 8'h20; cmd_len = 8'd4; cmd_mode = 2'b00; cmd_valid = 1'b1;
    step();
    for (int i = 0; i < 4; i++) begin
      cmd_start = 8'($urandom_range(0, 255));
      cmd_len   = 8'($urandom_range(0, 3));
      step();
    end
    cmd_start = 8'h80; cmd_len = 8'd2; cmd_mode = 2'b01;
    held_target = accepts[NDUT-1] + 1;
    for (int n = 0; n < 40 && accepts[NDUT-1] < held_target; n++) step();
    chk("held_cmd_accepted", NDUT - 1, 32'(accepts[NDUT-1]), 32'(held_target));
    cmd_valid = 1'b0;
    wait_idle();

    // Reset in the middle of a long burst
    burst(8'h30, 8'd15, 2'b00);
    repeat (5) step();
    do_reset();
    repeat (3) step();
    reset_n = 1'b1;
    repeat (12) step();

    // Recovery after reset
    burst(8'h55, 8'd5, 2'b01);
    burst(8'($urandom_range(0, 255)), 8'($urandom_range(0, 10)), 2'($urandom_range(0, 3)));
    wait_idle();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
